// File: rtl/alarm_responder_if.sv
// Panel-side bundle of the alarm responder: voter input, operator controls and status outputs.
interface alarm_responder_if #(
    parameter int CNT_W = 8
);
    logic             vote_f;
    logic             arm;
    logic             disarm;
    logic             ack;
    logic             siren;
    logic             armed;
    logic [1:0]       state;
    logic [CNT_W-1:0] event_count;

    modport slave (
        input  vote_f, arm, disarm, ack,
        output siren, armed, state, event_count
    );

    modport master (
        output vote_f, arm, disarm, ack,
        input  siren, armed, state, event_count
    );
endinterface

// File: rtl/alarm_responder.sv
// Debounces the active-low sensor vote and runs the arm/trip/acknowledge machine driving the siren.
// Optional trip counter is built only when EVENT_COUNT_EN is defined; otherwise event_count is 0.
module alarm_responder #(
    parameter int DEBOUNCE = 4,
    parameter int HOLD     = 16,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    alarm_responder_if.slave    bus
);
    typedef enum logic [1:0] {
        S_DISARMED = 2'b00,
        S_ARMED    = 2'b01,
        S_PENDING  = 2'b10,
        S_ALARM    = 2'b11
    } state_t;

    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [7:0] HOLD_INIT = 8'(HOLD);

    state_t     state_q, state_d;
    logic [7:0] deb_cnt_q, deb_cnt_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       siren_q, siren_d;
    logic       armed_q, armed_d;
    logic       trip;
    logic       hold_done;

    // hold_cnt reaches zero at this very edge, so the ack exit lands exactly HOLD edges after entry
    assign hold_done = (hold_cnt_q <= 8'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_DISARMED;
            deb_cnt_q  <= 8'd0;
            hold_cnt_q <= 8'd0;
            siren_q    <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            siren_q    <= siren_d;
            armed_q    <= armed_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        trip       = 1'b0;
        case (state_q)
            S_DISARMED: begin
                deb_cnt_d = 8'd0;
                if (bus.arm && !bus.disarm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (bus.disarm) begin
                    state_d = S_DISARMED;
                end else if (!bus.vote_f) begin
                    if (DEBOUNCE == 1) begin
                        state_d = S_ALARM;
                        trip    = 1'b1;
                    end else begin
                        state_d   = S_PENDING;
                        deb_cnt_d = 8'd1;
                    end
                end
            end
            S_PENDING: begin
                if (bus.disarm) begin
                    state_d   = S_DISARMED;
                    deb_cnt_d = 8'd0;
                end else if (bus.vote_f) begin
                    state_d   = S_ARMED;
                    deb_cnt_d = 8'd0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = S_ALARM;
                    deb_cnt_d = 8'd0;
                    trip      = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 8'd1;
                end
            end
            S_ALARM: begin
                hold_cnt_d = (hold_cnt_q == 8'd0) ? 8'd0 : hold_cnt_q - 8'd1;
                if (bus.disarm) begin
                    state_d = S_DISARMED;
                end else if (bus.ack && hold_done && bus.vote_f) begin
                    state_d = S_ARMED;
                end
            end
            default: state_d = S_DISARMED;
        endcase
        if (trip) hold_cnt_d = HOLD_INIT;
    end

    always_comb begin
        siren_d = (state_d == S_ALARM);
        armed_d = (state_d != S_DISARMED);
    end

    assign bus.siren = siren_q;
    assign bus.armed = armed_q;
    assign bus.state = state_q;

`ifdef EVENT_COUNT_EN
    logic [CNT_W-1:0] event_count_q, event_count_d;

    always_comb begin
        event_count_d = event_count_q;
        if (trip && (event_count_q != {CNT_W{1'b1}})) event_count_d = event_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) event_count_q <= '0;
        else       event_count_q <= event_count_d;
    end

    assign bus.event_count = event_count_q;
`else
    assign bus.event_count = '0;
`endif
endmodule

// File: tb/tb_alarm_responder.sv
// Directed bench for alarm_responder with DEBOUNCE=4, HOLD=16, CNT_W=8.
module tb_alarm_responder;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   exp_ev = 0;

    alarm_responder_if #(.CNT_W(8)) bus ();

    alarm_responder #(
        .DEBOUNCE (4),
        .HOLD     (16),
        .CNT_W    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // one clock edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ev_expect();
`ifdef EVENT_COUNT_EN
        return exp_ev;
`else
        return 0;
`endif
    endfunction

    task automatic note_trip();
        if (exp_ev < 255) exp_ev++;
    endtask

    task automatic arm_once();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    // four low samples from ARMED; the fourth edge enters ALARM
    task automatic trip_now();
        bus.vote_f = 1'b0;
        repeat (4) tick();
        bus.vote_f = 1'b1;
        note_trip();
    endtask

    initial begin
        reset      = 1'b1;
        bus.vote_f = 1'b1;
        bus.arm    = 1'b0;
        bus.disarm = 1'b0;
        bus.ack    = 1'b0;
        tick();
        tick();
        check_val("reset_state", int'(bus.state), 0);
        check_val("reset_siren", int'(bus.siren), 0);
        check_val("reset_armed", int'(bus.armed), 0);
        check_val("reset_evcnt", int'(bus.event_count), 0);
        reset = 1'b0;

        // DISARMED ignores the vote
        bus.vote_f = 1'b0;
        repeat (5) tick();
        check_val("disarmed_ignores_vote", int'(bus.state), 0);
        bus.vote_f = 1'b1;

        // 1: arm, then idle with vote high
        arm_once();
        check_val("arm_state", int'(bus.state), 1);
        check_val("arm_armed", int'(bus.armed), 1);
        check_val("arm_siren", int'(bus.siren), 0);
        repeat (100) tick();
        check_val("armed_idle_100", int'(bus.state), 1);

        // 2: four low samples trip
        bus.vote_f = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("pending_edge%0d", i), int'(bus.state), 2);
            check_val($sformatf("pending_siren%0d", i), int'(bus.siren), 0);
        end
        tick();
        note_trip();
        check_val("trip_state", int'(bus.state), 3);
        check_val("trip_siren", int'(bus.siren), 1);
        check_val("trip_evcnt", int'(bus.event_count), ev_expect());

        // 4: ack held from entry with vote high exits exactly 16 edges after entry
        bus.vote_f = 1'b1;
        bus.ack    = 1'b1;
        repeat (14) tick();
        tick();
        check_val("ack_edge15_held", int'(bus.state), 3);
        tick();
        check_val("ack_edge16_exit", int'(bus.state), 1);
        check_val("ack_exit_siren", int'(bus.siren), 0);
        bus.ack = 1'b0;

        // 3: broken debounce never trips; the fourth consecutive low does
        bus.vote_f = 1'b0;
        repeat (3) tick();
        check_val("deb_3low", int'(bus.state), 2);
        bus.vote_f = 1'b1;
        tick();
        check_val("deb_restart", int'(bus.state), 1);
        bus.vote_f = 1'b0;
        repeat (3) tick();
        check_val("deb_3low_again", int'(bus.state), 2);
        tick();
        note_trip();
        check_val("deb_4th_trips", int'(bus.state), 3);
        check_val("deb_4th_evcnt", int'(bus.event_count), ev_expect());

        // 4b: ack with vote low is ignored, even long after the hold
        bus.ack = 1'b1;
        repeat (20) tick();
        check_val("ack_vote_low_stays", int'(bus.state), 3);
        bus.ack    = 1'b0;
        bus.vote_f = 1'b1;
        tick();
        check_val("latched_alarm", int'(bus.siren), 1);

        // 5: disarm in ALARM at hold_cnt=10
        bus.disarm = 1'b1;
        tick();
        bus.disarm = 1'b0;
        check_val("disarm_alarm_state", int'(bus.state), 0);
        arm_once();
        trip_now();
        check_val("retrip_state", int'(bus.state), 3);
        repeat (6) tick();
        check_val("alarm_hold10_siren", int'(bus.siren), 1);
        bus.disarm = 1'b1;
        tick();
        bus.disarm = 1'b0;
        check_val("disarm_hold10_state", int'(bus.state), 0);
        check_val("disarm_hold10_siren", int'(bus.siren), 0);
        check_val("disarm_hold10_armed", int'(bus.armed), 0);

        // disarm during PENDING
        arm_once();
        bus.vote_f = 1'b0;
        repeat (2) tick();
        check_val("pending_before_disarm", int'(bus.state), 2);
        bus.disarm = 1'b1;
        tick();
        check_val("disarm_pending", int'(bus.state), 0);
        bus.arm = 1'b1;
        tick();
        check_val("arm_and_disarm", int'(bus.state), 0);
        bus.arm    = 1'b0;
        bus.disarm = 1'b0;
        bus.vote_f = 1'b1;

        // 6: reset mid-ALARM
        arm_once();
        trip_now();
        check_val("pre_reset_alarm", int'(bus.state), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ev = 0;
        check_val("midalarm_reset_state", int'(bus.state), 0);
        check_val("midalarm_reset_siren", int'(bus.siren), 0);
        check_val("midalarm_reset_armed", int'(bus.armed), 0);
        check_val("midalarm_reset_evcnt", int'(bus.event_count), 0);

        // 300 trips saturate the counter
        for (int n = 0; n < 300; n++) begin
            arm_once();
            trip_now();
            bus.disarm = 1'b1;
            tick();
            bus.disarm = 1'b0;
            if (n == 9) check_val("evcnt_after_10", int'(bus.event_count), ev_expect());
        end
        check_val("evcnt_saturated", int'(bus.event_count), ev_expect());
        check_val("after_trips_state", int'(bus.state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
